// File: rtl/debouncer_bank.sv
// debouncer_bank: per-channel polarity fix, synchroniser, debounce counter
// with registered edge pulses, and an optional long-press detector.
// Channels are fully independent; only clk and reset are shared.
module debouncer_bank #(
   parameter int                  CHANNELS        = 4,
   parameter int                  DEBOUNCE_CYCLES = 1000000,
   parameter int                  SYNC_STAGES     = 2,
   parameter int                  LONG_CYCLES     = 0,
   parameter logic [CHANNELS-1:0] INVERT          = {CHANNELS{1'b0}}
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] noisy,
   output logic [CHANNELS-1:0] clean,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] long_press,
   output logic [CHANNELS-1:0] held
);

   localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync;
      logic                   s;
      logic [CW-1:0]          cnt;
      logic                   clean_q;
      logic                   rise_q;
      logic                   fall_q;
      logic                   change;
      logic                   expire;

      // Polarity-corrected input shifted through the synchroniser chain.
      always_ff @(posedge clk) begin
         if (reset) begin
            sync <= '0;
         end else begin
            sync <= {sync[SYNC_STAGES-2:0], noisy[i] ^ INVERT[i]};
         end
      end

      assign s      = sync[SYNC_STAGES-1];
      assign change = (s != clean_q);
      // The cycle in which the input has disagreed long enough to be accepted.
      assign expire = change && (cnt == CNT_MAX);

      // Debounce counter: any agreement with clean restarts the count.
      always_ff @(posedge clk) begin
         if (reset) begin
            cnt     <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
         end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (expire) begin
               cnt     <= '0;
               clean_q <= s;
               rise_q  <= s;
               fall_q  <= ~s;
            end else if (change) begin
               cnt <= cnt + CW'(1);
            end else begin
               cnt <= '0;
            end
         end
      end

      assign clean[i] = clean_q;
      assign rise[i]  = rise_q;
      assign fall[i]  = fall_q;

      if (LONG_CYCLES > 0) begin : g_hold
         localparam int            HW       = $clog2(LONG_CYCLES + 1);
         localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);

         logic [HW-1:0] hcnt;
         logic          held_q;
         logic          long_q;

         // Hold timer: counts while pressed and not yet held, saturates once
         // held; a falling clean edge wins over reaching the threshold.
         always_ff @(posedge clk) begin
            if (reset) begin
               hcnt   <= '0;
               held_q <= 1'b0;
               long_q <= 1'b0;
            end else begin
               long_q <= 1'b0;
               if (expire && clean_q) begin
                  hcnt   <= '0;
                  held_q <= 1'b0;
               end else if (clean_q && !held_q) begin
                  if (hcnt == HOLD_MAX) begin
                     held_q <= 1'b1;
                     long_q <= 1'b1;
                  end else begin
                     hcnt <= hcnt + HW'(1);
                  end
               end
            end
         end

         assign long_press[i] = long_q;
         assign held[i]       = held_q;
      end else begin : g_no_hold
         assign long_press[i] = 1'b0;
         assign held[i]       = 1'b0;
      end
   end

endmodule

// File: tb/tb_debouncer_bank.sv
// Directed bench for debouncer_bank with a short debounce window and a
// ten-cycle long-press threshold; expected values are hand-computed.
module tb_debouncer_bank;

   logic       clk;
   logic       reset;
   logic [3:0] noisy;
   logic [3:0] clean;
   logic [3:0] rise;
   logic [3:0] fall;
   logic [3:0] long_press;
   logic [3:0] held;

   int checks;
   int errors;

   debouncer_bank #(
      .CHANNELS       (4),
      .DEBOUNCE_CYCLES(4),
      .SYNC_STAGES    (2),
      .LONG_CYCLES    (10),
      .INVERT         (4'b0010)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .noisy     (noisy),
      .clean     (clean),
      .rise      (rise),
      .fall      (fall),
      .long_press(long_press),
      .held      (held)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // Advance one edge and settle before sampling or driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      noisy = 4'b0010;
      reset = 1'b1;
      for (int j = 0; j < 3; j++) begin
         tick();
         checks++;
         if ({clean, rise, fall, long_press, held} !== 20'h0) begin
            errors++;
            $display("FAIL reset_hold cycle %0d: got %h, expected 0", j, {clean, rise, fall, long_press, held});
         end
      end
      reset = 1'b0;
      for (int j = 0; j < 20; j++) begin
         tick();
         checks++;
         if ({clean, rise, fall, long_press, held} !== 20'h0) begin
            errors++;
            $display("FAIL reset_idle cycle %0d: got %h, expected 0", j, {clean, rise, fall, long_press, held});
         end
      end
   endtask

   task automatic test_clean_press();
      noisy[0] = 1'b1;
      for (int j = 0; j <= 6; j++) begin
         tick();
         checks++;
         if (clean[0] !== (j >= 5) || rise[0] !== (j == 5) || long_press[0] !== 1'b0) begin
            errors++;
            $display("FAIL press_ch0 edge k+%0d: got clean=%b rise=%b lp=%b, expected clean=%b rise=%b lp=0",
                     j, clean[0], rise[0], long_press[0], j >= 5, j == 5);
         end
      end
      noisy[0] = 1'b0;
      for (int j = 0; j <= 6; j++) begin
         tick();
         checks++;
         if (clean[0] !== (j < 5) || fall[0] !== (j == 5) || long_press[0] !== 1'b0) begin
            errors++;
            $display("FAIL release_ch0 edge k+%0d: got clean=%b fall=%b lp=%b, expected clean=%b fall=%b lp=0",
                     j, clean[0], fall[0], long_press[0], j < 5, j == 5);
         end
      end
   endtask

   task automatic test_bounce();
      for (int seg = 0; seg < 2; seg++) begin
         noisy[0] = 1'b1;
         for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if (clean[0] !== 1'b0 || rise[0] !== 1'b0) begin
               errors++;
               $display("FAIL bounce_high seg %0d cycle %0d: got clean=%b rise=%b, expected 0 0", seg, j, clean[0], rise[0]);
            end
         end
         noisy[0] = 1'b0;
         tick();
         checks++;
         if (clean[0] !== 1'b0 || rise[0] !== 1'b0) begin
            errors++;
            $display("FAIL bounce_low seg %0d: got clean=%b rise=%b, expected 0 0", seg, clean[0], rise[0]);
         end
      end
      for (int j = 0; j < 10; j++) begin
         tick();
         checks++;
         if (clean[0] !== 1'b0 || rise[0] !== 1'b0) begin
            errors++;
            $display("FAIL bounce_settle cycle %0d: got clean=%b rise=%b, expected 0 0", j, clean[0], rise[0]);
         end
      end
   endtask

   task automatic test_long_press();
      noisy[2] = 1'b1;
      for (int j = 0; j < 30; j++) begin
         tick();
         checks++;
         if (clean[2] !== (j >= 5) || rise[2] !== (j == 5) ||
             long_press[2] !== (j == 15) || held[2] !== (j >= 15)) begin
            errors++;
            $display("FAIL long_ch2 edge k+%0d: got clean=%b rise=%b lp=%b held=%b, expected %b %b %b %b",
                     j, clean[2], rise[2], long_press[2], held[2], j >= 5, j == 5, j == 15, j >= 15);
         end
      end
      noisy[2] = 1'b0;
      for (int j = 0; j <= 7; j++) begin
         tick();
         checks++;
         if (clean[2] !== (j < 5) || fall[2] !== (j == 5) ||
             held[2] !== (j < 5) || long_press[2] !== 1'b0) begin
            errors++;
            $display("FAIL long_release_ch2 edge k+%0d: got clean=%b fall=%b held=%b lp=%b, expected %b %b %b 0",
                     j, clean[2], fall[2], held[2], long_press[2], j < 5, j == 5, j < 5);
         end
      end
   endtask

   task automatic test_inverted();
      noisy[1] = 1'b0;
      for (int j = 0; j <= 6; j++) begin
         tick();
         checks++;
         if (clean[1] !== (j >= 5) || rise[1] !== (j == 5)) begin
            errors++;
            $display("FAIL inv_press_ch1 edge k+%0d: got clean=%b rise=%b, expected %b %b", j, clean[1], rise[1], j >= 5, j == 5);
         end
      end
      noisy[1] = 1'b1;
      for (int j = 0; j <= 6; j++) begin
         tick();
         checks++;
         if (clean[1] !== (j < 5) || fall[1] !== (j == 5)) begin
            errors++;
            $display("FAIL inv_release_ch1 edge k+%0d: got clean=%b fall=%b, expected %b %b", j, clean[1], fall[1], j < 5, j == 5);
         end
      end
   endtask

   task automatic test_parallel_reset();
      noisy[0] = 1'b1;
      noisy[3] = 1'b1;
      for (int j = 0; j <= 6; j++) begin
         tick();
         checks++;
         if (clean[0] !== (j >= 5) || clean[3] !== (j >= 5) ||
             rise[0] !== (j == 5) || rise[3] !== (j == 5)) begin
            errors++;
            $display("FAIL parallel edge k+%0d: got clean0=%b clean3=%b rise0=%b rise3=%b, expected clean=%b rise=%b",
                     j, clean[0], clean[3], rise[0], rise[3], j >= 5, j == 5);
         end
      end
      noisy[0] = 1'b0;
      for (int j = 0; j < 4; j++) begin
         tick();
         checks++;
         if (clean[0] !== 1'b1 || fall[0] !== 1'b0) begin
            errors++;
            $display("FAIL midcount_ch0 edge k+%0d: got clean=%b fall=%b, expected 1 0", j, clean[0], fall[0]);
         end
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (clean !== 4'b0000 || fall !== 4'b0000 || rise !== 4'b0000 || held !== 4'b0000) begin
         errors++;
         $display("FAIL midcount_reset: got clean=%b fall=%b rise=%b held=%b, expected all 0", clean, fall, rise, held);
      end
      for (int j = 0; j < 10; j++) begin
         tick();
         checks++;
         if (clean[0] !== 1'b0 || fall[0] !== 1'b0 || rise[0] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_ch0 cycle %0d: got clean=%b fall=%b rise=%b, expected 0 0 0", j, clean[0], fall[0], rise[0]);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      noisy  = 4'b0010;
      test_reset();
      test_clean_press();
      test_bounce();
      test_long_press();
      test_inverted();
      test_parallel_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/debouncer_bank.md
# debouncer_bank

Multi-channel button/switch conditioner that replaces single-input debouncing across the HIL front panel. It takes `CHANNELS` raw asynchronous inputs and runs each one through a configurable synchroniser chain with per-channel polarity. Each channel then has its own debounce counter, which produces a clean level plus registered rise/fall pulses. An optional long-press detector per channel drives menu/repeat logic downstream. All channels are independent and share one clock and reset.

## Interface
- `CHANNELS`, 4: number of independent input channels (>=1)
- `DEBOUNCE_CYCLES`, 1000000: consecutive cycles a synchronised input must differ from `clean` before `clean` follows it (>=1)
- `SYNC_STAGES`, 2: synchroniser flop depth per channel (>=2)
- `LONG_CYCLES`, 0: cycles `clean` must stay high before `long_press` fires; 0 disables the detector
- `INVERT`, {CHANNELS{1'b0}}: per-channel polarity mask; bit=1 means the input is active-low and is inverted before synchronisation
- `clk` input 1: clock
- `reset` input 1: synchronous reset, active-high
- `noisy` input CHANNELS: raw asynchronous inputs
- `clean` output CHANNELS: debounced active-high level
- `rise` output CHANNELS: 1-cycle pulse when `clean` goes 0->1
- `fall` output CHANNELS: 1-cycle pulse when `clean` goes 1->0
- `long_press` output CHANNELS: 1-cycle pulse when the hold threshold is reached
- `held` output CHANNELS: level, high from `long_press` until `clean` falls

## Operation
- Per channel, the value `x = noisy[i] ^ INVERT[i]` feeds a `SYNC_STAGES`-deep flop chain; the last stage is `s`.
- Debounce counter width is `$clog2(DEBOUNCE_CYCLES+1)`. It is unsigned and never wraps, because it is cleared before it can exceed `DEBOUNCE_CYCLES-1`.
- When `s != clean` and `cnt < DEBOUNCE_CYCLES-1`, the edge does `cnt <= cnt+1`.
- When `s != clean` and `cnt == DEBOUNCE_CYCLES-1`, the edge does `clean <= s` and `cnt <= 0`, and pulses `rise` or `fall` accordingly.
- When `s == clean`, the edge does `cnt <= 0`. Any bounce therefore restarts the count.
- Hold counter width is `$clog2(LONG_CYCLES+1)`. It counts only while `clean==1` and `held==0`.
- When the hold counter reaches `LONG_CYCLES-1`, the next edge sets `held`, pulses `long_press`, and freezes the counter (saturates; no repeat).
- When `clean` falls, the same edge clears the hold counter and `held`.
- If `LONG_CYCLES==0`, the hold logic is not generated and `long_press`/`held` are tied to 0.
- Reset clears all sync flops, `cnt`, the hold counter, `clean`, `rise`, `fall`, `long_press` and `held` to 0. After reset, an inverted channel with its input idle-high reads as released (`s=0`), with no spurious pulse.
- Reset asserted mid-count discards the partial count. After reset, debouncing restarts from `cnt=0`.

## Timing
- Input edge captured by sync stage 1 at edge k gives `s` valid after edge k+SYNC_STAGES-1.
- `clean`, `rise` and `fall` update at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1, provided the input is stable throughout.
- `rise`/`fall` are registered and high for exactly the one cycle in which `clean` first shows the new value.
- `long_press` rises at the edge that is `LONG_CYCLES` cycles after the `rise` edge, in the cycle `held` first reads 1.
- A release before that edge produces no `long_press`.
- Channels never interact. Simultaneous transitions on several channels are handled in parallel, in the same cycle.
- All outputs are registered; there is no combinational path from `noisy` to any output.

## Test plan
Bench parameters for all scenarios: CHANNELS=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2, LONG_CYCLES=10, INVERT=4'b0010.
- **Reset:** assert `reset` 3 cycles with `noisy=4'b0010` -> all outputs 0 during and after reset; no pulses in the 20 cycles that follow.
- **Clean press:** `noisy[0]` 0->1 before edge k and held -> `clean[0]`=1 and `rise[0]` pulse at edge k+5; `rise[0]` low at k+6.
- **Bounce rejection:** `noisy[0]` toggles 1,0,1,0 with 3-cycle high segments, then returns low -> `clean[0]` stays 0 and no `rise`.
- **Long press and release:** `noisy[2]` held high 30 cycles, then low -> `rise[2]` at edge k+5 and `long_press[2]` at k+15. `held[2]`=1 until `clean[2]` falls, at which point `fall[2]` pulses and `held[2]` clears on the same edge.
- **Inverted channel:** `noisy[1]` 1->0 (pressed) -> `clean[1]` rises after 5 edges; `noisy[1]` back to 1 -> `fall[1]` after 5 edges.
- **Parallel press and mid-count reset:** `noisy[3]` and `noisy[0]` rise on the same cycle -> identical `rise` timing on both channels. Then `noisy[0]` falls, and `reset` pulses while its count is 2, followed by stable low -> `clean[0]`=0 immediately after reset with no `fall` pulse.
